// File: rtl/phj_release_pkg.sv
// rtl/phj_release_pkg.sv - shared state type, record layout and pointer-width helper for phj_ordered_release
package phj_release_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        TERM  = 2'd2,
        DONE  = 2'd3
    } release_state_t;

    localparam int PHJ_DATA_W = 128;
    localparam int PHJ_SN_W   = 32;

    // Record layout at the default integration widths.
    typedef struct packed {
        logic [PHJ_DATA_W-1:0] data;
        logic [PHJ_SN_W-1:0]   serialnum;
        logic                  joined;
    } release_rec_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/phj_ordered_release_if.sv
// rtl/phj_ordered_release_if.sv - per-channel record inputs and ordered output stream bundle
interface phj_ordered_release_if #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 128,
    parameter int SN_W   = 32
);
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH*SN_W-1:0]   in_serialnum;
    logic [NUM_CH-1:0]        in_joined;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH-1:0]        in_last;
    logic [DATA_W-1:0]        out_data;
    logic [SN_W-1:0]          out_serialnum;
    logic                     out_joined;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;

    modport master (
        output in_data, in_serialnum, in_joined, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_serialnum, out_joined, out_valid, out_last
    );

    modport slave (
        input  in_data, in_serialnum, in_joined, in_valid, in_last, out_ready,
        output in_ready, out_data, out_serialnum, out_joined, out_valid, out_last
    );

endinterface

// File: rtl/phj_sn_fifo.sv
// rtl/phj_sn_fifo.sv - single-channel record FIFO with registered full/empty and combinational head
module phj_sn_fifo
    import phj_release_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int SN_W   = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [SN_W-1:0]   wr_sn,
    input  logic              wr_joined,
    input  logic              rd_en,
    output logic [DATA_W-1:0] head_data,
    output logic [SN_W-1:0]   head_sn,
    output logic              head_joined,
    output logic              full,
    output logic              empty
);
    localparam int AW = clog2(DEPTH);
    localparam int W  = DATA_W + SN_W + 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          do_wr, do_rd;

    always_comb begin
        do_wr  = wr_en && !full_q;
        do_rd  = rd_en && !empty_q;
        wptr_d = do_wr ? wptr_q + AW'(1) : wptr_q;
        rptr_d = do_rd ? rptr_q + AW'(1) : rptr_q;
        cnt_d  = cnt_q;
        if (do_wr && !do_rd) cnt_d = cnt_q + (AW+1)'(1);
        else if (do_rd && !do_wr) cnt_d = cnt_q - (AW+1)'(1);
        full_d  = (cnt_d == FULL_CNT);
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= {wr_joined, wr_sn, wr_data};
    end

    assign {head_joined, head_sn, head_data} = mem_q[rptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/phj_ordered_release.sv
// rtl/phj_ordered_release.sv - serial-number-ordered release of per-channel join results; PHJ_RELEASE_OUTER_EN emits unjoined records too
module phj_ordered_release
    import phj_release_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 128,
    parameter int SN_W   = 32,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    phj_ordered_release_if.slave io,
    output logic [SN_W-1:0]      next_sn,
    output logic                 err
);
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_TERM  = TERM;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [NUM_CH-1:0] full, empty, wr_en, pop, first_oh, in_rdy, head_joined;
    logic [DATA_W-1:0] head_data [NUM_CH];
    logic [SN_W-1:0]   head_sn   [NUM_CH];

    logic [1:0]        state_q, state_d;
    logic [NUM_CH-1:0] last_q, last_d;
    logic [SN_W-1:0]   next_sn_q, next_sn_d, out_sn_q, out_sn_d, sel_sn;
    logic [DATA_W-1:0] out_data_q, out_data_d, sel_data;
    logic              err_q, err_d, rdy_en_q, rdy_en_d;
    logic              out_valid_q, out_valid_d, out_last_q, out_last_d, out_joined_q, out_joined_d;
    logic              found, multi, out_free, active, rel_en, emit, sel_joined;

    assign in_rdy = rdy_en_q ? ~full : '0;
    assign wr_en  = io.in_valid & in_rdy;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        phj_sn_fifo #(.DATA_W(DATA_W), .SN_W(SN_W), .DEPTH(DEPTH)) u_fifo (
            .clk         (clk),
            .resetn      (resetn),
            .wr_en       (wr_en[c]),
            .wr_data     (io.in_data[c*DATA_W +: DATA_W]),
            .wr_sn       (io.in_serialnum[c*SN_W +: SN_W]),
            .wr_joined   (io.in_joined[c]),
            .rd_en       (pop[c]),
            .head_data   (head_data[c]),
            .head_sn     (head_sn[c]),
            .head_joined (head_joined[c]),
            .full        (full[c]),
            .empty       (empty[c])
        );
    end

    always_comb begin
        found      = 1'b0;
        multi      = 1'b0;
        first_oh   = '0;
        sel_data   = '0;
        sel_sn     = '0;
        sel_joined = 1'b0;
        // Lowest matching channel wins; any second match is a protocol error.
        for (int c = 0; c < NUM_CH; c++) begin
            if (!empty[c] && head_sn[c] == next_sn_q) begin
                if (found) begin
                    multi = 1'b1;
                end else begin
                    found       = 1'b1;
                    first_oh[c] = 1'b1;
                    sel_data    = head_data[c];
                    sel_sn      = head_sn[c];
                    sel_joined  = head_joined[c];
                end
            end
        end

        out_free = !out_valid_q || io.out_ready;
        active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        rel_en   = found && out_free && active;
        pop      = rel_en ? first_oh : '0;
`ifdef PHJ_RELEASE_OUTER_EN
        emit     = rel_en;
`else
        emit     = rel_en && sel_joined;
`endif

        last_d       = last_q | io.in_last;
        err_d        = err_q | multi;
        next_sn_d    = rel_en ? next_sn_q + SN_W'(1) : next_sn_q;
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        out_sn_d     = out_sn_q;
        out_joined_d = out_joined_q;

        if (out_valid_q && io.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        if (emit) begin
            out_valid_d  = 1'b1;
            out_data_d   = sel_data;
            out_sn_d     = sel_sn;
            out_joined_d = sel_joined;
        end

        case (state_q)
            ST_RUN:   if (&last_q) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (&empty && out_free) begin
                    state_d      = ST_TERM;
                    out_valid_d  = 1'b1;
                    out_last_d   = 1'b1;
                    out_data_d   = '0;
                    out_sn_d     = next_sn_q;
                    out_joined_d = 1'b0;
                end
            end
            ST_TERM:  if (io.out_ready) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase

        rdy_en_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_RUN;
            last_q       <= '0;
            next_sn_q    <= '0;
            err_q        <= 1'b0;
            rdy_en_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            out_sn_q     <= '0;
            out_joined_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            next_sn_q    <= next_sn_d;
            err_q        <= err_d;
            rdy_en_q     <= rdy_en_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            out_sn_q     <= out_sn_d;
            out_joined_q <= out_joined_d;
        end
    end

    assign io.in_ready      = in_rdy;
    assign io.out_valid     = out_valid_q;
    assign io.out_last      = out_last_q;
    assign io.out_data      = out_data_q;
    assign io.out_serialnum = out_sn_q;
    assign io.out_joined    = out_joined_q;
    assign next_sn          = next_sn_q;
    assign err              = err_q;

endmodule

// File: tb/tb_phj_ordered_release.sv
// tb/tb_phj_ordered_release.sv - randomized scoreboard bench for phj_ordered_release
module tb_phj_ordered_release;
    localparam int NCH = 8;
    localparam int DW  = 16;
    localparam int SW  = 4;
    localparam int DP  = 4;
`ifdef PHJ_RELEASE_OUTER_EN
    localparam bit OUTER = 1'b1;
`else
    localparam bit OUTER = 1'b0;
`endif

    typedef struct {
        int            ch;
        logic [SW-1:0] sn;
        logic          joined;
        logic [DW-1:0] data;
    } rec_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [SW-1:0] next_sn;
    logic          err;

    phj_ordered_release_if #(.NUM_CH(NCH), .DATA_W(DW), .SN_W(SW)) bus ();

    phj_ordered_release #(.NUM_CH(NCH), .DATA_W(DW), .SN_W(SW), .DEPTH(DP)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .io      (bus),
        .next_sn (next_sn),
        .err     (err)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    rec_t          stage[$];
    rec_t          pend[$];
    rec_t          expq[$];
    logic [SW-1:0] model_sn;
    logic [SW-1:0] s;
    bit            force_stall;
    bit            stall_seen;
    logic [DW-1:0] stall_data;
    bit            got_term;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_rec(input int ch, input logic [SW-1:0] sn, input logic joined, input logic [DW-1:0] data);
        rec_t r;
        r.ch = ch; r.sn = sn; r.joined = joined; r.data = data;
        stage.push_back(r);
    endtask

    // Reference: records leave in serial order starting at model_sn; the lowest
    // channel wins a duplicated serial; unjoined ones vanish unless outer mode.
    task automatic commit_phase(input int n);
        for (int k = 0; k < n; k++) begin
            int best;
            best = -1;
            for (int i = 0; i < stage.size(); i++)
                if (stage[i].sn == SW'(model_sn + k) && (best < 0 || stage[i].ch < stage[best].ch)) best = i;
            if (best >= 0 && (stage[best].joined || OUTER)) expq.push_back(stage[best]);
        end
        model_sn = SW'(model_sn + n);
        foreach (stage[i]) pend.push_back(stage[i]);
        stage.delete();
    endtask

    function automatic int find_head(input int ch);
        for (int i = 0; i < pend.size(); i++) if (pend[i].ch == ch) return i;
        return -1;
    endfunction

    function automatic int count_ch(input int ch);
        int n;
        n = 0;
        foreach (pend[i]) if (pend[i].ch == ch) n++;
        return n;
    endfunction

    task automatic monitor();
        rec_t e;
        if (bus.out_valid && bus.out_ready && !bus.out_last) begin
            check_eq("beat_expected", 64'(expq.size() != 0), 64'd1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                check_eq("out_serialnum", bus.out_serialnum, e.sn);
                check_eq("out_data", bus.out_data, e.data);
                check_eq("out_joined", bus.out_joined, e.joined);
            end
        end
        if (bus.out_valid && !bus.out_ready) begin
            if (stall_seen) check_eq("stall_stable", bus.out_data, stall_data);
            stall_seen = 1'b1;
            stall_data = bus.out_data;
        end else begin
            stall_seen = 1'b0;
        end
        for (int c = 0; c < NCH; c++) begin
            if (bus.in_valid[c] && bus.in_ready[c]) begin
                int idx;
                idx = find_head(c);
                if (idx >= 0) pend.delete(idx);
            end
        end
    endtask

    task automatic drive(input bit rnd);
        for (int c = 0; c < NCH; c++) begin
            int idx;
            idx = find_head(c);
            if (idx >= 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
                bus.in_valid[c]              = 1'b1;
                bus.in_data[c*DW +: DW]      = pend[idx].data;
                bus.in_serialnum[c*SW +: SW] = pend[idx].sn;
                bus.in_joined[c]             = pend[idx].joined;
            end else begin
                bus.in_valid[c] = 1'b0;
            end
        end
        bus.out_ready = force_stall ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
    endtask

    task automatic run_cycles(input int n, input bit rnd);
        repeat (n) begin
            @(negedge clk);
            monitor();
            @(posedge clk);
            #1;
            drive(rnd);
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((pend.size() != 0 || expq.size() != 0) && k < budget) begin
            run_cycles(1, 1'b1);
            k++;
        end
        check_eq("drain_left", 64'(pend.size() + expq.size()), 64'd0);
        run_cycles(3, 1'b1);
        check_eq("next_sn", next_sn, model_sn);
    endtask

    task automatic random_phase(input int n);
        for (int k = 0; k < n; k++)
            add_rec($urandom_range(0, NCH-1), SW'(model_sn + k), $urandom_range(0, 2) != 0, 16'($urandom));
        commit_phase(n);
        drain(400);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.in_valid = '0; bus.in_data = '0; bus.in_serialnum = '0;
        bus.in_joined = '0; bus.in_last = '0; bus.out_ready = 1'b0;
        force_stall = 1'b0; stall_seen = 1'b0; model_sn = '0;

        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", bus.in_ready, 8'h00);
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_out_last", bus.out_last, 1'b0);
        check_eq("rst_out_data", bus.out_data, 16'h0);
        check_eq("rst_next_sn", next_sn, 4'h0);
        check_eq("rst_err", err, 1'b0);
        resetn = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_in_ready", bus.in_ready, 8'hFF);

        // Single channel, serials 0..2 back to back: each visible two cycles after acceptance.
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.in_valid[0]          = (k < 3);
            bus.in_serialnum[SW-1:0] = SW'(k);
            bus.in_data[DW-1:0]      = 16'hA000 + 16'(k);
            bus.in_joined[0]         = 1'b1;
            @(negedge clk);
            check_eq("lat_valid", bus.out_valid, 64'(k >= 2 && k <= 4));
            if (k >= 2 && k <= 4) begin
                check_eq("lat_sn", bus.out_serialnum, 64'(k - 2));
                check_eq("lat_data", bus.out_data, 16'hA000 + 16'(k - 2));
            end
            @(posedge clk); #1;
        end
        model_sn = 4'd3;
        check_eq("lat_next_sn", next_sn, model_sn);

        // Cross-channel reorder plus an unjoined record in the middle.
        s = model_sn;
        add_rec(3, SW'(s + 1), 1'b1, 16'h3001);
        add_rec(5, s,          1'b1, 16'h5000);
        add_rec(0, SW'(s + 2), 1'b1, 16'h0002);
        add_rec(1, SW'(s + 3), 1'b1, 16'h1003);
        add_rec(2, SW'(s + 4), 1'b0, 16'h2004);
        add_rec(1, SW'(s + 5), 1'b1, 16'h1005);
        commit_phase(6);
        drain(200);

        for (int p = 0; p < 8; p++) random_phase($urandom_range(1, 12));

        // Backpressure: ch1 parks serial s in the output register, ch0 fills its FIFO behind it.
        s = model_sn;
        add_rec(1, s, 1'b1, 16'h1111);
        for (int k = 1; k <= 6; k++) add_rec(0, SW'(s + k), 1'b1, 16'h0C00 + 16'(k));
        commit_phase(7);
        force_stall = 1'b1;
        run_cycles(10, 1'b0);
        check_eq("bp_in_ready0", bus.in_ready[0], 1'b0);
        check_eq("bp_ch0_left", count_ch(0), 2);
        check_eq("bp_out_valid", bus.out_valid, 1'b1);
        check_eq("bp_out_sn", bus.out_serialnum, s);
        check_eq("bp_out_data", bus.out_data, 16'h1111);
        force_stall = 1'b0;
        drain(200);

        // Two channels present the awaited serial together.
        s = model_sn;
        add_rec(2, s, 1'b1, 16'h2222);
        add_rec(4, s, 1'b1, 16'h4444);
        commit_phase(1);
        force_stall = 1'b1;
        run_cycles(5, 1'b0);
        check_eq("dup_err", err, 1'b1);
        check_eq("dup_out_valid", bus.out_valid, 1'b1);
        check_eq("dup_out_sn", bus.out_serialnum, s);
        check_eq("dup_out_data", bus.out_data, 16'h2222);
        check_eq("dup_next_sn", next_sn, model_sn);

        @(negedge clk); #2;
        resetn = 1'b0;
        #1;
        check_eq("async_rst_err", err, 1'b0);
        check_eq("async_rst_next_sn", next_sn, 4'h0);
        check_eq("async_rst_out_valid", bus.out_valid, 1'b0);
        check_eq("async_rst_in_ready", bus.in_ready, 8'h00);
        bus.in_valid = '0;
        pend.delete(); expq.delete(); stage.delete();
        model_sn = '0; force_stall = 1'b0; stall_seen = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Advance to 14, then cross the wrap with 14,15,0,1 spread over channels.
        random_phase(int'(SW'(4'd14 - model_sn)));
        add_rec(2, 4'd14, 1'b1, 16'hE00E);
        add_rec(6, 4'd15, 1'b1, 16'hF00F);
        add_rec(1, 4'd0,  1'b1, 16'h0A00);
        add_rec(7, 4'd1,  1'b1, 16'h0A01);
        commit_phase(4);
        drain(200);

        bus.out_ready = 1'b0;
        bus.in_last   = '1;
        got_term = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                got_term = 1'b1;
                break;
            end
        end
        check_eq("term_seen", got_term, 1'b1);
        check_eq("term_last", bus.out_last, 1'b1);
        check_eq("term_sn", bus.out_serialnum, model_sn);
        check_eq("term_data", bus.out_data, 16'h0);
        check_eq("term_joined", bus.out_joined, 1'b0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("done_out_valid", bus.out_valid, 1'b0);
        check_eq("done_out_last", bus.out_last, 1'b0);
        check_eq("done_in_ready", bus.in_ready, 8'h00);
        repeat (3) @(negedge clk);
        check_eq("done_hold_valid", bus.out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
